// File: rtl/pattern_generator.sv
// Serial stimulus source: shifts a latched pattern out MSB-first for a number of
// passes and predicts the run-of-ones detector output for the emitted stream.
module pattern_generator #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 4,
  parameter int RUN_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  output logic             busy,
  output logic             d,
  output logic             d_valid,
  output logic             exp_q,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [RUN_W-1:0] run_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pat_q    <= '0;
      bit_cnt  <= '0;
      pass_cnt <= '0;
      run_cnt  <= '0;
      busy     <= 1'b0;
      d        <= 1'b0;
      d_valid  <= 1'b0;
      exp_q    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (repeats != '0) begin
              state    <= SHIFT;
              pat_q    <= pattern;
              pass_cnt <= repeats;
              bit_cnt  <= LAST_BIT;
              busy     <= 1'b1;
              d_valid  <= 1'b1;
              d        <= pattern[WIDTH-1];
            end else begin
              done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // pass_cnt counts passes still owed, including the one in flight
          if (bit_cnt == '0) begin
            if (pass_cnt == CNT_W'(1)) begin
              state   <= IDLE;
              busy    <= 1'b0;
              d_valid <= 1'b0;
              d       <= 1'b0;
              done    <= 1'b1;
            end else begin
              pass_cnt <= pass_cnt - 1'b1;
              bit_cnt  <= LAST_BIT;
              d        <= pat_q[WIDTH-1];
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            d       <= pat_q[bit_cnt - 1'b1];
          end
        end
        default: state <= IDLE;
      endcase

      // Prediction uses the run seen before the current bit, not the bit itself
      if (d_valid) begin
        exp_q <= (run_cnt >= RUN_MAX);
        if (d) begin
          run_cnt <= (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        end else begin
          run_cnt <= '0;
        end
      end else begin
        exp_q   <= 1'b0;
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Scoreboard bench for pattern_generator: two instances (RUN_LEN=2 and RUN_LEN=1)
// with hand-computed expected bit/prediction tables checked by a negedge monitor.
module tb_pattern_generator;

  localparam int W  = 8;
  localparam int CW = 4;

  typedef struct {
    logic d;
    logic e;
    int   gap;
  } item_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start   [2];
  logic [W-1:0]  pattern [2];
  logic [CW-1:0] repeats [2];
  logic          busy    [2];
  logic          d       [2];
  logic          d_valid [2];
  logic          exp_q   [2];
  logic          done    [2];

  item_t sb     [2][$];
  int    done_q [2][$];

  logic  pend_v    [2];
  logic  pend_e    [2];
  int    low_cnt   [2];
  int    since_val [2];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pattern_generator #(.WIDTH(W), .CNT_W(CW), .RUN_LEN(2)) dut (
    .clk(clk), .reset(reset), .start(start[0]), .pattern(pattern[0]),
    .repeats(repeats[0]), .busy(busy[0]), .d(d[0]), .d_valid(d_valid[0]),
    .exp_q(exp_q[0]), .done(done[0])
  );

  pattern_generator #(.WIDTH(W), .CNT_W(CW), .RUN_LEN(1)) dut_r1 (
    .clk(clk), .reset(reset), .start(start[1]), .pattern(pattern[1]),
    .repeats(repeats[1]), .busy(busy[1]), .d(d[1]), .d_valid(d_valid[1]),
    .exp_q(exp_q[1]), .done(done[1])
  );

  task automatic check(input int u, input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL u%0d %s: got %0d expected %0d at %0t", u, name, act, req, $time);
  endtask

  // Monitor: consumes expected bits whenever d_valid is presented
  always @(negedge clk) begin
    item_t it;
    int    dq;
    for (int u = 0; u < 2; u++) begin
      if (!reset) begin
        pend_v[u]    = 1'b0;
        low_cnt[u]   = -1;
        since_val[u] = -1;
      end else begin
        if (pend_v[u]) check(u, "exp_q", int'(exp_q[u]), int'(pend_e[u]));
        else           check(u, "exp_q_idle", int'(exp_q[u]), 0);
        check(u, "busy", int'(busy[u]), int'(d_valid[u]));
        if (d_valid[u]) begin
          if (sb[u].size() == 0) begin
            check(u, "unexpected_bit", 1, 0);
            pend_v[u] = 1'b0;
          end else begin
            it = sb[u].pop_front();
            check(u, "d", int'(d[u]), int'(it.d));
            if (it.gap >= 0) check(u, "gap", low_cnt[u], it.gap);
            pend_v[u] = 1'b1;
            pend_e[u] = it.e;
          end
          low_cnt[u]   = 0;
          since_val[u] = 0;
        end else begin
          check(u, "d_idle", int'(d[u]), 0);
          pend_v[u] = 1'b0;
          if (low_cnt[u] >= 0)   low_cnt[u]++;
          if (since_val[u] >= 0) since_val[u]++;
        end
        if (done[u]) begin
          if (done_q[u].size() == 0) begin
            check(u, "spurious_done", 1, 0);
          end else begin
            dq = done_q[u].pop_front();
            if (dq >= 0) check(u, "done_pos", since_val[u], dq);
          end
        end
      end
    end
  end

  // first_exp/next_exp: expected exp_q per bit, MSB = first bit of the pass
  task automatic push_burst(input int u, input logic [W-1:0] pat, input int reps,
                            input logic [W-1:0] first_exp, input logic [W-1:0] next_exp,
                            input int gap0);
    item_t it;
    for (int p = 0; p < reps; p++) begin
      for (int b = W - 1; b >= 0; b--) begin
        it.d   = pat[b];
        it.e   = (p == 0) ? first_exp[b] : next_exp[b];
        it.gap = (p == 0 && b == W - 1) ? gap0 : 0;
        sb[u].push_back(it);
      end
    end
    done_q[u].push_back(reps == 0 ? -1 : 1);
  endtask

  task automatic issue(input int u, input logic [W-1:0] pat, input logic [CW-1:0] reps);
    @(posedge clk); #1;
    start[u]   = 1'b1;
    pattern[u] = pat;
    repeats[u] = reps;
    @(posedge clk); #1;
    start[u] = 1'b0;
  endtask

  task automatic drain(input int u, input int budget);
    int n;
    n = 0;
    while ((sb[u].size() != 0 || done_q[u].size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(u, "drain_left", sb[u].size() + done_q[u].size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_zero(input int u, input string tag);
    check(u, {tag, "_busy"},    int'(busy[u]),    0);
    check(u, {tag, "_d"},       int'(d[u]),       0);
    check(u, {tag, "_d_valid"}, int'(d_valid[u]), 0);
    check(u, {tag, "_exp_q"},   int'(exp_q[u]),   0);
    check(u, {tag, "_done"},    int'(done[u]),    0);
  endtask

  initial begin
    item_t it;
    for (int u = 0; u < 2; u++) begin
      start[u]     = 1'b0;
      pattern[u]   = '0;
      repeats[u]   = '0;
      pend_v[u]    = 1'b0;
      pend_e[u]    = 1'b0;
      low_cnt[u]   = -1;
      since_val[u] = -1;
    end
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "rst");
    check_zero(1, "rst");
    reset = 1'b1;

    // Basic single pass
    push_burst(0, 8'b0111_0110, 1, 8'b0001_1001, 8'h00, -1);
    issue(0, 8'b0111_0110, 4'd1);
    drain(0, 40);

    // Two passes of all ones: continuous across the pass boundary
    push_burst(0, 8'hFF, 2, 8'b0011_1111, 8'hFF, -1);
    issue(0, 8'hFF, 4'd2);
    drain(0, 60);

    // Zero passes: done only
    push_burst(0, 8'h5A, 0, 8'h00, 8'h00, -1);
    issue(0, 8'h5A, 4'd0);
    drain(0, 20);

    // Start re-pulsed mid-burst is ignored
    push_burst(0, 8'b1100_1010, 1, 8'b0010_0000, 8'h00, -1);
    issue(0, 8'b1100_1010, 4'd1);
    repeat (2) @(posedge clk);
    #1;
    start[0] = 1'b1; pattern[0] = 8'hFF; repeats[0] = 4'd3;
    @(posedge clk); #1;
    start[0] = 1'b0;
    drain(0, 60);

    // Start held through done: back-to-back with exactly one idle cycle
    push_burst(0, 8'b1110_0111, 1, 8'b0011_0001, 8'h00, -1);
    push_burst(0, 8'b1111_0000, 1, 8'b0011_1000, 8'h00, 1);
    @(posedge clk); #1;
    start[0] = 1'b1; pattern[0] = 8'b1110_0111; repeats[0] = 4'd1;
    @(posedge clk); #1;
    pattern[0] = 8'b1111_0000;
    repeat (9) @(posedge clk);
    #1;
    start[0] = 1'b0;
    drain(0, 60);

    // Asynchronous reset in the fourth bit of 8'hF0: no done, outputs cleared
    for (int b = 0; b < 3; b++) begin
      it.d   = 1'b1;
      it.e   = (b == 2);
      it.gap = (b == 0) ? -1 : 0;
      sb[0].push_back(it);
    end
    issue(0, 8'hF0, 4'd1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_zero(0, "arst");
    @(posedge clk); #1;
    check_zero(0, "arst_hold");
    reset = 1'b1;
    repeat (12) @(posedge clk);
    check(0, "arst_left", sb[0].size() + done_q[0].size(), 0);
    push_burst(0, 8'b0011_1100, 1, 8'b0000_1110, 8'h00, -1);
    issue(0, 8'b0011_1100, 4'd1);
    drain(0, 40);

    // Maximum pass count; runs carry across pass boundaries
    push_burst(0, 8'b0000_0011, 15, 8'b0000_0000, 8'b1000_0000, -1);
    issue(0, 8'b0000_0011, 4'd15);
    drain(0, 200);

    // RUN_LEN=1 instance
    push_burst(1, 8'b1010_1011, 1, 8'b0101_0101, 8'h00, -1);
    issue(1, 8'b1010_1011, 4'd1);
    drain(1, 40);
    push_burst(1, 8'b1010_1011, 2, 8'b0101_0101, 8'b1101_0101, -1);
    issue(1, 8'b1010_1011, 4'd2);
    drain(1, 60);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/pattern_generator.md
Name: pattern_generator

Overview:
Serial test-stimulus source for the run-of-ones pattern detector. The block loads a WIDTH-bit pattern word and a pass count, then shifts the pattern out MSB-first, one bit per clock, for the requested number of passes. In parallel it produces exp_q, a registered golden prediction of the detector output for the emitted stream. It sits on the bench/BIST side and drives the detector's serial d input; exp_q is compared against the detector's q.

Parameters:
WIDTH, 8, pattern word length in bits (>=2)
CNT_W, 4, width of the pass-count input
RUN_LEN, 2, number of consecutive prior 1s after which exp_q asserts (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request a burst; sampled only in IDLE
pattern  input  WIDTH  pattern word; latched on accepted start
repeats  input  CNT_W  number of passes; latched on accepted start
busy  output  1  high while the burst is in progress
d  output  1  serial data bit; 0 when d_valid=0
d_valid  output  1  d carries a pattern bit this cycle
exp_q  output  1  predicted detector output, lags d by one cycle
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, d, d_valid, exp_q and done all 0; shift register, bit counter, pass counter and run counter cleared. Reset mid-burst aborts the burst silently, with no done pulse.
- FSM has two states, IDLE and SHIFT.
- IDLE with start=1 at edge E0 and repeats!=0:
  - Latch pattern and repeats.
  - Go to SHIFT; busy=1, d_valid=1, d=pattern[WIDTH-1] from E0.
- IDLE with start=1 and repeats==0: stay IDLE, no bits emitted, done=1 for the cycle after E0.
- SHIFT:
  - Each edge advances one bit, MSB to LSB.
  - After bit 0 of a pass, the next pass begins on the following edge with bit WIDTH-1. There are no gap cycles; d_valid stays high continuously.
  - Total valid bits = WIDTH*repeats.
  - At the edge ending the last bit: go to IDLE; busy=0, d_valid=0, d=0, done=1 for exactly one cycle.
- start while busy=1 is ignored, and pattern/repeats changes mid-burst have no effect.
- start asserted during the done cycle is accepted, because that cycle is IDLE. A back-to-back burst therefore begins with d_valid low for exactly one cycle.
- Golden model, evaluated every edge:
  - If d_valid=1: exp_q <= (run_cnt >= RUN_LEN); run_cnt <= d ? min(run_cnt+1, RUN_LEN) : 0.
  - If d_valid=0: exp_q <= 0; run_cnt <= 0.
  - run_cnt saturates at RUN_LEN and is $clog2(RUN_LEN+1) bits wide.
  - Runs carry across pass boundaries within a burst and clear between bursts.
  - The current bit's value does not affect its own exp_q; only the prior run does.
- Pass counter and bit counter wrap cleanly at maximum values: repeats=2^CNT_W-1 yields exactly that many passes.

Test Plan:
- WIDTH=8, RUN_LEN=2, pattern=8'b0111_0110, repeats=1, start pulse at E0 -> d=0,1,1,1,0,1,1,0 over cycles 1-8 with d_valid=1 and busy=1; exp_q=0,0,0,1,1,0,0,1 over cycles 2-9; done=1 in cycle 9 only.
- pattern=8'hFF, repeats=2 -> 16 consecutive 1s, no d_valid gap at the pass boundary; exp_q=0,0 then 1 for 14 cycles; done in cycle 17.
- repeats=0, start -> d_valid never asserts; busy stays 0; done=1 the next cycle; exp_q=0.
- start re-pulsed mid-burst with a different pattern -> ignored, original sequence unchanged. start held high through the done cycle -> new burst begins, d_valid low exactly one cycle between bursts, run_cnt cleared (first exp_q of the new burst = 0).
- reset asserted asynchronously at bit 3 of pattern 8'hF0 -> all outputs 0 immediately, no done pulse; after release, a new start works normally.
- RUN_LEN=1, pattern=8'b1010_1011 -> exp_q=0,1,0,1,0,1,0,1 over cycles 2-9.
